// File: rtl/vending_pkg.sv
// ============================================================================
//  Module   : vending_pkg
//  Purpose  : Shared state, coin and change encodings for the vending FSM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package vending_pkg;

    typedef enum logic [1:0] {
        S0  = 2'b00,
        S5  = 2'b01,
        S10 = 2'b10
    } state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    localparam logic [1:0] CHG_NONE  = 2'b00;
    localparam logic [1:0] CHG_5     = 2'b01;
    localparam logic [1:0] CHG_10    = 2'b10;

    localparam int unsigned PRICE    = 15;

endpackage : vending_pkg

`default_nettype wire

// File: rtl/vending_machine.sv
// ============================================================================
//  Module   : vending_machine
//  Purpose  : Single-product (15 unit) coin FSM with registered vend/change.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vending_machine
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic       out,
    output logic [1:0] change
);

    state_e     state_q, state_d;
    logic       out_q,   out_d;
    logic [1:0] chg_q,   chg_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            out_q   <= 1'b0;
            chg_q   <= CHG_NONE;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            chg_q   <= chg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = 1'b0;
        chg_d   = CHG_NONE;

        case (state_q)
            S0: begin
                case (in)
                    COIN_5:    state_d = S5;
                    COIN_10:   state_d = S10;
                    COIN_NONE: state_d = S0;
                    default:   state_d = state_q;
                endcase
            end

            S5: begin
                case (in)
                    COIN_NONE: begin
                        state_d = S0;
                        chg_d   = CHG_5;
                    end
                    COIN_5:    state_d = S10;
                    COIN_10: begin
                        state_d = S0;
                        out_d   = 1'b1;
                    end
                    default:   state_d = state_q;
                endcase
            end

            S10: begin
                case (in)
                    COIN_NONE: begin
                        state_d = S0;
                        chg_d   = CHG_10;
                    end
                    COIN_5: begin
                        state_d = S0;
                        out_d   = 1'b1;
                    end
                    // 20 paid against a price of 15: vend and hand back a five
                    COIN_10: begin
                        state_d = S0;
                        out_d   = 1'b1;
                        chg_d   = CHG_5;
                    end
                    default:   state_d = state_q;
                endcase
            end

            // Unreachable encoding: drop credit silently and restart
            default: begin
                state_d = S0;
            end
        endcase
    end

    assign out    = out_q;
    assign change = chg_q;

endmodule : vending_machine

`default_nettype wire

// File: tb/tb_vending_machine.sv
// ============================================================================
//  Module   : tb_vending_machine
//  Purpose  : Directed scoreboard bench for the vending FSM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vending_machine;

    logic       clk;
    logic       rst;
    logic [1:0] in;
    logic       out;
    logic [1:0] change;

    int n_checks;
    int n_fails;

    logic [2:0] exp_q[$];

    vending_machine dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .out    (out),
        .change (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge worth of stimulus, queue its expected result, then check it
    task automatic step(input string tag, input logic r, input logic [1:0] coin,
                        input logic eo, input logic [1:0] ec);
        logic [2:0] e;
        @(negedge clk);
        rst = r;
        in  = coin;
        exp_q.push_back({eo, ec});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        assert ({out, change} === e)
        else begin
            n_fails++;
            $error("FAIL %s: out/change observed %b/%b expected %b/%b",
                   tag, out, change, e[2], e[1:0]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        in       = 2'b00;

        step("reset",        1'b1, 2'b00, 1'b0, 2'b00);
        step("idle0",        1'b0, 2'b00, 1'b0, 2'b00);
        step("idle1",        1'b0, 2'b00, 1'b0, 2'b00);
        step("idle2",        1'b0, 2'b00, 1'b0, 2'b00);

        step("5a",           1'b0, 2'b01, 1'b0, 2'b00);
        step("5b",           1'b0, 2'b01, 1'b0, 2'b00);
        step("5c_vend",      1'b0, 2'b01, 1'b1, 2'b00);
        step("after_5c",     1'b0, 2'b00, 1'b0, 2'b00);

        step("10_5_a",       1'b0, 2'b10, 1'b0, 2'b00);
        step("10_5_vend",    1'b0, 2'b01, 1'b1, 2'b00);
        step("after_10_5",   1'b0, 2'b00, 1'b0, 2'b00);

        step("over_a",       1'b0, 2'b10, 1'b0, 2'b00);
        step("over_vend",    1'b0, 2'b10, 1'b1, 2'b01);
        step("over_again",   1'b0, 2'b10, 1'b0, 2'b00);
        step("over_vend2",   1'b0, 2'b10, 1'b1, 2'b01);
        step("after_over",   1'b0, 2'b00, 1'b0, 2'b00);

        step("ref5_coin",    1'b0, 2'b01, 1'b0, 2'b00);
        step("ref5",         1'b0, 2'b00, 1'b0, 2'b01);
        step("ref5_s0",      1'b0, 2'b00, 1'b0, 2'b00);
        step("ref10_coin",   1'b0, 2'b10, 1'b0, 2'b00);
        step("ref10",        1'b0, 2'b00, 1'b0, 2'b10);
        step("ref10_s0",     1'b0, 2'b00, 1'b0, 2'b00);

        step("55_a",         1'b0, 2'b01, 1'b0, 2'b00);
        step("55_b",         1'b0, 2'b01, 1'b0, 2'b00);
        step("55_ref10",     1'b0, 2'b00, 1'b0, 2'b10);

        step("inv_s5_coin",  1'b0, 2'b01, 1'b0, 2'b00);
        step("inv_s5",       1'b0, 2'b11, 1'b0, 2'b00);
        step("inv_s5_vend",  1'b0, 2'b10, 1'b1, 2'b00);
        step("inv_s0",       1'b0, 2'b11, 1'b0, 2'b00);
        step("inv_s0_idle",  1'b0, 2'b00, 1'b0, 2'b00);
        step("inv_s10_coin", 1'b0, 2'b10, 1'b0, 2'b00);
        step("inv_s10",      1'b0, 2'b11, 1'b0, 2'b00);
        step("inv_s10_vend", 1'b0, 2'b01, 1'b1, 2'b00);

        step("b2b_a",        1'b0, 2'b01, 1'b0, 2'b00);
        step("b2b_vend",     1'b0, 2'b10, 1'b1, 2'b00);
        step("b2b_new",      1'b0, 2'b01, 1'b0, 2'b00);
        step("b2b_ref5",     1'b0, 2'b00, 1'b0, 2'b01);

        step("mid_coin",     1'b0, 2'b10, 1'b0, 2'b00);
        step("mid_rst",      1'b1, 2'b00, 1'b0, 2'b00);
        step("mid_after",    1'b0, 2'b00, 1'b0, 2'b00);
        step("prio_rst",     1'b1, 2'b10, 1'b0, 2'b00);
        step("prio_after",   1'b0, 2'b00, 1'b0, 2'b00);
        step("prio_s5",      1'b0, 2'b01, 1'b0, 2'b00);
        step("prio_rst_vend",1'b1, 2'b10, 1'b0, 2'b00);
        step("prio_idle",    1'b0, 2'b00, 1'b0, 2'b00);

        n_checks++;
        assert (exp_q.size() == 0)
        else begin
            n_fails++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_vending_machine

`default_nettype wire
